// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, register constants and mem_writeback state encoding
package cpu_pkg;

    localparam int OP_SLL   = 1;
    localparam int OP_ADDI  = 2;
    localparam int OP_MUL   = 3;
    localparam int OP_MOVE  = 4;
    localparam int OP_MOVEI = 5;
    localparam int OP_ADD   = 6;
    localparam int OP_LW    = 9;
    localparam int OP_SW    = 10;
    localparam int OP_HALT  = 12;
    localparam int OP_MULI  = 13;
    localparam int OP_JAL   = 14;
    localparam int OP_ORI   = 15;
    localparam int OP_LUI   = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_HALT = 2'd3
    } mwb_state_t;

endpackage

// File: rtl/mem_writeback_if.sv
// rtl/mem_writeback_if.sv - execute, data-memory and writeback signals of mem_writeback
interface mem_writeback_if #(parameter int OP_W = 6);

    logic            ex_valid;
    logic [OP_W-1:0] ex_op;
    logic [4:0]      ex_dst;
    logic [31:0]     ex_result;
    logic [31:0]     ex_store_data;
    logic            ex_stall;

    logic [31:0]     dmem_address;
    logic [31:0]     dmem_wdata;
    logic [31:0]     dmem_rdata;
    logic            dmem_read;
    logic            dmem_write;
    logic            dmem_ready;

    logic            wb_en;
    logic [4:0]      wb_dst;
    logic [31:0]     wb_data;
    logic            retire;
    logic            halted;
    logic            mem_err;

    // Upstream/memory side: drives execute instruction and memory responses.
    modport master (
        output ex_valid, ex_op, ex_dst, ex_result, ex_store_data, dmem_rdata, dmem_ready,
        input  ex_stall, dmem_address, dmem_wdata, dmem_read, dmem_write,
        input  wb_en, wb_dst, wb_data, retire, halted, mem_err
    );

    modport slave (
        input  ex_valid, ex_op, ex_dst, ex_result, ex_store_data, dmem_rdata, dmem_ready,
        output ex_stall, dmem_address, dmem_wdata, dmem_read, dmem_write,
        output wb_en, wb_dst, wb_data, retire, halted, mem_err
    );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter and timeout compare for outstanding memory accesses
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int CNT_W = (MEM_TIMEOUT < 16) ? 4 : $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Count is 0 on the first request cycle because it is held clear while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!active) begin
            count <= '0;
        end else if (!ready) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (MEM_TIMEOUT > 0) && active && !ready && (count == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - memory-access/writeback stage; MEMWB_PERF_CNT_EN adds perf counters
module mem_writeback
    import cpu_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    mem_writeback_if.slave bus
`ifdef MEMWB_PERF_CNT_EN
    ,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_mem_stall
`endif
);

    mwb_state_t  state;
    logic [4:0]  rd_dst;
    logic        expired;
    logic        busy_mem;

    logic [31:0] dmem_address_q;
    logic [31:0] dmem_wdata_q;
    logic        dmem_read_q;
    logic        dmem_write_q;
    logic        wb_en_q;
    logic [4:0]  wb_dst_q;
    logic [31:0] wb_data_q;
    logic        retire_q;
    logic        halted_q;
    logic        mem_err_q;

    assign busy_mem = (state == ST_RD) || (state == ST_WR);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .active  (busy_mem),
        .ready   (bus.dmem_ready),
        .expired (expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            rd_dst         <= REG_ZERO;
            dmem_address_q <= '0;
            dmem_wdata_q   <= '0;
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_dst_q       <= '0;
            wb_data_q      <= '0;
            retire_q       <= 1'b0;
            halted_q       <= 1'b0;
            mem_err_q      <= 1'b0;
        end else begin
            retire_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            mem_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ex_valid) begin
                        if (bus.ex_op == OP_W'(OP_LW)) begin
                            state          <= ST_RD;
                            dmem_read_q    <= 1'b1;
                            dmem_address_q <= bus.ex_result;
                            rd_dst         <= bus.ex_dst;
                        end else if (bus.ex_op == OP_W'(OP_SW)) begin
                            state          <= ST_WR;
                            dmem_write_q   <= 1'b1;
                            dmem_address_q <= bus.ex_result;
                            dmem_wdata_q   <= bus.ex_store_data;
                        end else if (bus.ex_op == OP_W'(OP_HALT)) begin
                            state    <= ST_HALT;
                            retire_q <= 1'b1;
                            halted_q <= 1'b1;
                        end else begin
                            retire_q <= 1'b1;
                            if (bus.ex_dst != REG_ZERO) begin
                                wb_en_q   <= 1'b1;
                                wb_dst_q  <= bus.ex_dst;
                                wb_data_q <= bus.ex_result;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (bus.dmem_ready) begin
                        dmem_read_q <= 1'b0;
                        state       <= ST_IDLE;
                        retire_q    <= 1'b1;
                        if (rd_dst != REG_ZERO) begin
                            wb_en_q   <= 1'b1;
                            wb_dst_q  <= rd_dst;
                            wb_data_q <= bus.dmem_rdata;
                        end
                    end else if (expired) begin
                        dmem_read_q <= 1'b0;
                        mem_err_q   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (bus.dmem_ready) begin
                        dmem_write_q <= 1'b0;
                        state        <= ST_IDLE;
                        retire_q     <= 1'b1;
                    end else if (expired) begin
                        dmem_write_q <= 1'b0;
                        mem_err_q    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEMWB_PERF_CNT_EN
    // Counting stops at the halt retire itself, since halted rises with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_retired   <= '0;
            perf_mem_stall <= '0;
        end else if (!halted_q) begin
            if (retire_q) perf_retired <= perf_retired + 32'd1;
            if (busy_mem) perf_mem_stall <= perf_mem_stall + 32'd1;
        end
    end
`endif

    assign bus.ex_stall     = (state != ST_IDLE);
    assign bus.dmem_address = dmem_address_q;
    assign bus.dmem_wdata   = dmem_wdata_q;
    assign bus.dmem_read    = dmem_read_q;
    assign bus.dmem_write   = dmem_write_q;
    assign bus.wb_en        = wb_en_q;
    assign bus.wb_dst       = wb_dst_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.retire       = retire_q;
    assign bus.halted       = halted_q;
    assign bus.mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_writeback.sv
// tb/tb_mem_writeback.sv - randomized scoreboard bench for mem_writeback
module tb_mem_writeback;
    import cpu_pkg::*;

    localparam int TMO = 4;
    localparam int K_NOWB = 0, K_WB = 1, K_ERR = 2, K_HALT = 3, K_BAD = 4;

    typedef struct {
        int          kind;
        logic [4:0]  dst;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } mem_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    mem_writeback_if #(.OP_W(6)) bus ();

`ifdef MEMWB_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_mem_stall;
`endif

    mem_writeback #(.OP_W(6), .MEM_TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (rst),
        .bus   (bus)
`ifdef MEMWB_PERF_CNT_EN
        ,
        .perf_retired   (perf_retired),
        .perf_mem_stall (perf_mem_stall)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    mem_t mem_q[$];
    logic [4:0]  last_dst   = '0;
    logic [31:0] last_data  = '0;
    bit          halted_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
        end
    endtask

    // Memory responder: checks request contents and hold time, answers after a chosen delay.
    mem_t cur;
    bit   r_active = 1'b0;
    int   r_cnt    = 0;
    always @(negedge clock) begin
        if (rst) begin
            r_active = 1'b0;
            bus.dmem_ready = 1'b0;
        end else if (bus.dmem_read || bus.dmem_write) begin
            if (!r_active) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_request", 32'd1, 32'd0);
                end else begin
                    cur = mem_q.pop_front();
                    r_active = 1'b1;
                    r_cnt = 0;
                end
            end
            if (r_active) begin
                check("mem_direction", {30'd0, bus.dmem_write, bus.dmem_read}, cur.wr ? 32'd2 : 32'd1);
                check("mem_address", bus.dmem_address, cur.addr);
                if (cur.wr) check("mem_wdata", bus.dmem_wdata, cur.wdata);
                bus.dmem_ready = (r_cnt == cur.delay);
                bus.dmem_rdata = (r_cnt == cur.delay) ? cur.rdata : $urandom;
                r_cnt++;
            end else begin
                bus.dmem_ready = 1'b0;
            end
        end else begin
            if (r_active) begin
                check("mem_hold_cycles", r_cnt, (cur.delay <= TMO) ? cur.delay + 1 : TMO + 1);
                r_active = 1'b0;
            end
            bus.dmem_ready = 1'($urandom_range(0, 1));
            bus.dmem_rdata = $urandom;
        end
    end

    // Output monitor: every retire/wb/mem_err event is matched against the expectation queue.
    exp_t e_mon;
    int   obs;
    always @(negedge clock) begin
        if (!rst) begin
            if (bus.retire || bus.wb_en || bus.mem_err) begin
                if (bus.mem_err) obs = (bus.retire || bus.wb_en) ? K_BAD : K_ERR;
                else if (bus.retire && bus.wb_en) obs = K_WB;
                else if (bus.retire && bus.halted) obs = K_HALT;
                else if (bus.retire) obs = K_NOWB;
                else obs = K_BAD;
                if (exp_q.size() == 0) begin
                    check("out_unexpected_event", obs, 32'hFFFF_FFFF);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("out_kind", obs, e_mon.kind);
                    if (e_mon.kind == K_WB) begin
                        check("wb_dst", bus.wb_dst, e_mon.dst);
                        check("wb_data", bus.wb_data, e_mon.data);
                        last_dst  = e_mon.dst;
                        last_data = e_mon.data;
                    end
                    if (e_mon.kind == K_HALT) halted_exp = 1'b1;
                end
            end else begin
                check("wb_dst_hold", bus.wb_dst, last_dst);
                check("wb_data_hold", bus.wb_data, last_data);
            end
            check("halted", bus.halted, halted_exp);
            check("rd_wr_exclusive", bus.dmem_read && bus.dmem_write, 1'b0);
        end
    end

    task automatic issue(input int op, input logic [4:0] dst, input logic [31:0] res,
                         input logic [31:0] sd, input int delay, input logic [31:0] rdata);
        exp_t e;
        mem_t m;
        bit   is_mem = (op == OP_LW) || (op == OP_SW);
        int   guard  = 0;
        while (bus.ex_stall) begin
            @(negedge clock);
            guard++;
            if (guard > 200) begin
                check("issue_wait_timeout", 32'd1, 32'd0);
                break;
            end
        end
        bus.ex_valid      = 1'b1;
        bus.ex_op         = 6'(op);
        bus.ex_dst        = dst;
        bus.ex_result     = res;
        bus.ex_store_data = sd;
        if (is_mem) begin
            m.wr = (op == OP_SW); m.addr = res; m.wdata = sd; m.rdata = rdata; m.delay = delay;
            mem_q.push_back(m);
        end
        e.dst  = dst;
        e.data = (op == OP_LW) ? rdata : res;
        if (op == OP_HALT) e.kind = K_HALT;
        else if (is_mem && delay > TMO) e.kind = K_ERR;
        else if (op == OP_SW || dst == 5'd0) e.kind = K_NOWB;
        else e.kind = K_WB;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        bus.ex_valid      = 1'b0;
        bus.ex_op         = 6'($urandom);
        bus.ex_dst        = 5'($urandom);
        bus.ex_result     = $urandom;
        bus.ex_store_data = $urandom;
        @(negedge clock);
        check("stall_after_issue", bus.ex_stall, is_mem || (op == OP_HALT));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, bus.ex_stall, 0);
        check({tag, "_dmem_read"}, bus.dmem_read, 0);
        check({tag, "_dmem_write"}, bus.dmem_write, 0);
        check({tag, "_dmem_address"}, bus.dmem_address, 0);
        check({tag, "_dmem_wdata"}, bus.dmem_wdata, 0);
        check({tag, "_wb"}, {bus.wb_en, bus.retire, bus.halted, bus.mem_err}, 0);
        check({tag, "_wb_dst"}, bus.wb_dst, 0);
        check({tag, "_wb_data"}, bus.wb_data, 0);
    endtask

    initial begin
        int r, op, guard;
        bus.ex_valid = 1'b0; bus.ex_op = '0; bus.ex_dst = '0;
        bus.ex_result = '0; bus.ex_store_data = '0;
        bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clock);

        issue(OP_ADDI, 5'd3, 32'h0000_002A, 32'h0, 0, 32'h0);
        issue(OP_LW, 5'd5, 32'h0000_0040, 32'h0, 2, 32'hDEAD_BEEF);
        issue(OP_SW, 5'd0, 32'h0000_0080, 32'h0000_1234, 0, 32'h0);
        issue(OP_LW, 5'd7, 32'h0000_0100, 32'h0, 99, 32'h0);
        issue(OP_ADDI, 5'd8, 32'h0000_0055, 32'h0, 0, 32'h0);
        issue(OP_LW, 5'd9, 32'h0000_0104, 32'h0, TMO, 32'hCAFE_F00D);
        issue(OP_SW, 5'd1, 32'h0000_0108, 32'h0000_5678, TMO + 1, 32'h0);
        issue(OP_SLL, 5'd0, 32'h0, 32'h0, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) op = OP_LW;
            else if (r < 5) op = OP_SW;
            else begin
                op = $urandom_range(0, 63);
                if (op == OP_LW || op == OP_SW || op == OP_HALT) op = OP_ADD;
            end
            issue(op, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom, $urandom_range(0, TMO + 2), $urandom);
            repeat ($urandom_range(0, 1)) @(negedge clock);
        end

        issue(OP_LW, 5'd11, 32'h0000_0200, 32'h0, 99, 32'h0);
        @(negedge clock);
        #1 rst = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        mem_q.delete();
        last_dst = '0; last_data = '0; halted_exp = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        issue(OP_ORI, 5'd12, 32'h0000_00F0, 32'h0, 0, 32'h0);
        issue(OP_LW, 5'd13, 32'h0000_0300, 32'h0, 1, 32'h1357_9BDF);

        issue(OP_ADDI, 5'd0, 32'h0000_0077, 32'h0, 0, 32'h0);
        issue(OP_HALT, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            bus.ex_valid = 1'b1;
            bus.ex_op    = (i % 2 == 0) ? 6'(OP_ADDI) : 6'(OP_LW);
            bus.ex_dst   = 5'd4;
            @(negedge clock);
            check("halt_stall", bus.ex_stall, 1'b1);
        end
        bus.ex_valid = 1'b0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("exp_queue_drained", exp_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
